// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network layer engines: default
// dimensions, the layer FSM state encoding and the output activation.
package nn_pkg;

    localparam int DEF_N_IN  = 784;
    localparam int DEF_N_OUT = 10;
    localparam int DEF_ACC_W = 32;
    localparam int DEF_B_W   = 16;
    localparam int DEF_SHIFT = 8;

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        MAC   = 3'd1,
        DRAIN = 3'd2,
        BIAS  = 3'd3,
        OUT   = 3'd4
    } state_t;

    // ReLU, arithmetic right shift, then saturate to an unsigned byte.
    function automatic logic [7:0] act_relu_sat(input logic signed [DEF_ACC_W-1:0] r,
                                                input int shift);
        logic signed [DEF_ACC_W-1:0] s;
        logic [7:0] y;
        s = r >>> shift;
        if (r < 32'sd0) begin
            y = 8'd0;
        end else if (s > 32'sd255) begin
            y = 8'd255;
        end else begin
            y = s[7:0];
        end
        return y;
    endfunction

endpackage

// File: rtl/dense_layer_mac_if.sv
// Bundle of the pixel stream, weight/bias ROM ports and activation stream
// of the dense layer. The master side is the layer engine itself.
interface dense_layer_mac_if
    import nn_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT,
    parameter int B_W   = DEF_B_W
);
    localparam int WA_W = $clog2(N_IN * N_OUT);
    localparam int N_W  = $clog2(N_OUT);

    logic                   pix_valid;
    logic [7:0]             pix_data;
    logic                   pix_ready;
    logic [WA_W-1:0]        w_addr;
    logic signed [7:0]      w_data;
    logic [N_W-1:0]         b_addr;
    logic signed [B_W-1:0]  b_data;
    logic                   out_valid;
    logic [7:0]             out_data;
    logic [N_W-1:0]         out_idx;
    logic                   out_ready;
    logic                   img_done;

    modport master (
        input  pix_valid, pix_data, w_data, b_data, out_ready,
        output pix_ready, w_addr, b_addr, out_valid, out_data, out_idx, img_done
    );

    modport slave (
        output pix_valid, pix_data, w_data, b_data, out_ready,
        input  pix_ready, w_addr, b_addr, out_valid, out_data, out_idx, img_done
    );

endinterface

// File: rtl/dense_layer_mac_pixel_buffer.sv
// Single-port image buffer: one write port, registered read data
// (one-cycle latency, read-before-write). Contents are never reset.
module pixel_buffer
    import nn_pkg::*;
#(
    parameter int DEPTH = DEF_N_IN,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Synchronous write and registered read of the pixel storage
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dense_layer_mac.sv
// Fully-connected layer engine: buffers one image, then computes each
// neuron with a single MAC against an external synchronous weight ROM,
// adds the bias, applies the activation and streams one byte per neuron.
module dense_layer_mac
    import nn_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT,
    parameter int ACC_W = DEF_ACC_W,
    parameter int B_W   = DEF_B_W,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic              clk,
    input  logic              rst,
    dense_layer_mac_if.master bus
);

    localparam int WA_W = $clog2(N_IN * N_OUT);
    localparam int N_W  = $clog2(N_OUT);
    localparam int K_W  = $clog2(N_IN);

    localparam logic [K_W-1:0]  K_ZERO  = {K_W{1'b0}};
    localparam logic [K_W-1:0]  K_ONE   = {{(K_W-1){1'b0}}, 1'b1};
    localparam logic [K_W-1:0]  K_LAST  = K_W'(N_IN - 1);
    localparam logic [N_W-1:0]  N_ZERO  = {N_W{1'b0}};
    localparam logic [N_W-1:0]  N_ONE   = {{(N_W-1){1'b0}}, 1'b1};
    localparam logic [N_W-1:0]  N_LAST  = N_W'(N_OUT - 1);
    localparam logic [WA_W-1:0] WA_ZERO = {WA_W{1'b0}};
    localparam logic [WA_W-1:0] WA_ONE  = {{(WA_W-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

    state_t                   state_r, state_s;
    logic [K_W-1:0]           p_r;
    logic [K_W-1:0]           k_r;
    logic [N_W-1:0]           n_r;
    logic [WA_W-1:0]          w_addr_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic                     pix_ready_r;
    logic                     out_valid_r;
    logic [7:0]               out_data_r;
    logic [N_W-1:0]           out_idx_r;
    logic                     img_done_r;

    logic                     pix_fire_s;
    logic                     out_fire_s;
    logic                     acc_en_s;
    logic                     buf_we_s;
    logic [K_W-1:0]           buf_addr_s;
    logic [7:0]               buf_rdata_s;
    logic signed [8:0]        pix_s;
    logic signed [7:0]        w_s;
    logic signed [B_W-1:0]    b_s;
    logic signed [16:0]       prod_s;
    logic signed [ACC_W-1:0]  prod_ext_s;
    logic signed [ACC_W-1:0]  bias_sum_s;
    logic [7:0]               act_s;

    pixel_buffer #(
        .DEPTH (N_IN),
        .AW    (K_W)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we_s),
        .addr  (buf_addr_s),
        .wdata (bus.pix_data),
        .rdata (buf_rdata_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and handshake / buffer / accumulate strobes
    always_comb begin
        state_s    = state_r;
        pix_fire_s = 1'b0;
        out_fire_s = 1'b0;
        case (state_r)
            LOAD: begin
                pix_fire_s = bus.pix_valid & pix_ready_r;
                if (pix_fire_s && (p_r == K_LAST)) begin
                    state_s = MAC;
                end else begin
                    state_s = LOAD;
                end
            end
            MAC: begin
                if (k_r == K_LAST) begin
                    state_s = DRAIN;
                end else begin
                    state_s = MAC;
                end
            end
            DRAIN: begin
                state_s = BIAS;
            end
            BIAS: begin
                state_s = OUT;
            end
            OUT: begin
                out_fire_s = bus.out_ready & out_valid_r;
                if (out_fire_s && (n_r == N_LAST)) begin
                    state_s = LOAD;
                end else if (out_fire_s) begin
                    state_s = MAC;
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                state_s = LOAD;
            end
        endcase
        buf_we_s = pix_fire_s;
        if (state_r == LOAD) begin
            buf_addr_s = p_r;
        end else begin
            buf_addr_s = k_r;
        end
        // The ROM and buffer data lag the address by one cycle, so the
        // product of k arrives while k+1 is addressed (or in DRAIN).
        acc_en_s = ((state_r == MAC) && (k_r != K_ZERO)) || (state_r == DRAIN);
    end

    // Product, bias sum and activation of the current neuron
    always_comb begin
        pix_s      = signed'({1'b0, buf_rdata_s});
        w_s        = bus.w_data;
        b_s        = bus.b_data;
        prod_s     = 17'(pix_s) * 17'(w_s);
        prod_ext_s = ACC_W'(prod_s);
        bias_sum_s = acc_r + ACC_W'(b_s);
        act_s      = act_relu_sat(bias_sum_s, SHIFT);
    end

    // Pixel, MAC and neuron counters, weight address and accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_r      <= K_ZERO;
            k_r      <= K_ZERO;
            n_r      <= N_ZERO;
            w_addr_r <= WA_ZERO;
            acc_r    <= ACC_ZERO;
        end else begin
            case (state_r)
                LOAD: begin
                    if (pix_fire_s && (p_r == K_LAST)) begin
                        p_r      <= K_ZERO;
                        k_r      <= K_ZERO;
                        n_r      <= N_ZERO;
                        w_addr_r <= WA_ZERO;
                        acc_r    <= ACC_ZERO;
                    end else if (pix_fire_s) begin
                        p_r <= p_r + K_ONE;
                    end
                end
                MAC: begin
                    if (acc_en_s) begin
                        acc_r <= acc_r + prod_ext_s;
                    end
                    // The address holds on the last weight of the neuron and
                    // steps to the next neuron's first weight on handshake.
                    if (k_r == K_LAST) begin
                        k_r <= K_ZERO;
                    end else begin
                        k_r      <= k_r + K_ONE;
                        w_addr_r <= w_addr_r + WA_ONE;
                    end
                end
                DRAIN: begin
                    acc_r <= acc_r + prod_ext_s;
                end
                BIAS: begin
                    acc_r <= acc_r;
                end
                OUT: begin
                    if (out_fire_s && (n_r != N_LAST)) begin
                        n_r      <= n_r + N_ONE;
                        acc_r    <= ACC_ZERO;
                        w_addr_r <= w_addr_r + WA_ONE;
                    end
                end
                default: begin
                    acc_r <= ACC_ZERO;
                end
            endcase
        end
    end

    // Registered stream outputs; img_done follows the final handshake edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_ready_r <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'd0;
            out_idx_r   <= N_ZERO;
            img_done_r  <= 1'b0;
        end else begin
            pix_ready_r <= (state_s == LOAD);
            img_done_r  <= out_fire_s && (n_r == N_LAST);
            if (state_r == BIAS) begin
                out_valid_r <= 1'b1;
                out_data_r  <= act_s;
                out_idx_r   <= n_r;
            end else if (out_fire_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.pix_ready = pix_ready_r;
    assign bus.w_addr    = w_addr_r;
    assign bus.b_addr    = n_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_idx   = out_idx_r;
    assign bus.img_done  = img_done_r;

endmodule

// File: tb/tb_dense_layer_mac.sv
// Directed bench for dense_layer_mac: a behavioural ROM model, a golden
// per-neuron model feeding a scoreboard queue, and a linear test sequence.
module tb_dense_layer_mac;
    import nn_pkg::*;

    localparam int N_IN   = DEF_N_IN;
    localparam int N_OUT  = DEF_N_OUT;
    localparam int NW     = N_IN * N_OUT;
    localparam int BUDGET = 3000;

    typedef struct {
        int idx;
        int data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   pix_mem [N_IN];
    int   wmem [NW];
    int   bmem [N_OUT];
    exp_t q [$];
    logic addr_mon = 1'b0;
    int   prev_addr = 0;

    always #5 clk = ~clk;

    dense_layer_mac_if #(.N_IN(N_IN), .N_OUT(N_OUT), .B_W(DEF_B_W)) bus ();

    dense_layer_mac #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .ACC_W (DEF_ACC_W),
        .B_W   (DEF_B_W),
        .SHIFT (DEF_SHIFT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous weight and bias ROMs, one cycle of read latency
    always @(posedge clk) begin
        bus.w_data <= (int'(bus.w_addr) < NW) ? 8'(wmem[int'(bus.w_addr)]) : 8'd0;
        bus.b_data <= (int'(bus.b_addr) < N_OUT) ? 16'(bmem[int'(bus.b_addr)]) : 16'd0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int golden(input int n);
        longint r;
        r = 0;
        for (int k = 0; k < N_IN; k++) begin
            r += longint'(pix_mem[k]) * longint'(wmem[n * N_IN + k]);
        end
        r += longint'(bmem[n]);
        if (r < 0) return 0;
        r = r / 256;
        if (r > 255) return 255;
        return int'(r);
    endfunction

    // Per-cycle checks while the engine is computing
    task automatic tick_checks();
        check("img_done_idle", 32'(bus.img_done), 32'd0);
        if (addr_mon && (int'(bus.w_addr) != prev_addr)) begin
            check("w_addr_order", 32'(bus.w_addr), 32'(prev_addr + 1));
            prev_addr = int'(bus.w_addr);
        end
    endtask

    task automatic load_image();
        int g;
        for (int p = 0; p < N_IN; p++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                bus.pix_valid = 1'b0;
                @(negedge clk);
            end
            bus.pix_valid = 1'b1;
            bus.pix_data  = 8'(pix_mem[p]);
            g = 0;
            while (bus.pix_ready !== 1'b1 && g < BUDGET) begin
                @(negedge clk);
                g++;
            end
            if (bus.pix_ready !== 1'b1) begin
                check("pix_ready_wait", 32'(bus.pix_ready), 32'd1);
                bus.pix_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        bus.pix_valid = 1'b0;
    endtask

    task automatic collect(input int count, input int stall_idx, input int stall_len);
        exp_t e;
        int   c;
        for (int i = 0; i < count; i++) begin
            bus.out_ready = (i == stall_idx) ? 1'b0 : 1'b1;
            c = 0;
            do begin
                @(negedge clk);
                c++;
                tick_checks();
            end while (bus.out_valid !== 1'b1 && c < BUDGET);
            if (bus.out_valid !== 1'b1) begin
                check("out_valid_wait", 32'(bus.out_valid), 32'd1);
                return;
            end
            check("latency", 32'(c), 32'(N_IN + 3));
            if (q.size() == 0) begin
                check("sb_nonempty", 32'd0, 32'd1);
                return;
            end
            e = q.pop_front();
            check("out_idx", 32'(bus.out_idx), 32'(e.idx));
            check("out_data", 32'(bus.out_data), 32'(e.data));
            check("w_addr_hold", 32'(bus.w_addr), 32'(e.idx * N_IN + N_IN - 1));
            if (i == stall_idx) begin
                bus.pix_valid = 1'b1;
                bus.pix_data  = 8'hA5;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    tick_checks();
                    check("stall_valid", 32'(bus.out_valid), 32'd1);
                    check("stall_data", 32'(bus.out_data), 32'(e.data));
                    check("stall_idx", 32'(bus.out_idx), 32'(e.idx));
                    check("stall_w_addr", 32'(bus.w_addr), 32'(e.idx * N_IN + N_IN - 1));
                    check("stall_pix_ready", 32'(bus.pix_ready), 32'd0);
                end
                bus.pix_valid = 1'b0;
                bus.out_ready = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (count == N_OUT) begin
            @(negedge clk);
            check("img_done_pulse", 32'(bus.img_done), 32'd1);
            check("pix_ready_back", 32'(bus.pix_ready), 32'd1);
            check("out_valid_clear", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
            check("img_done_single", 32'(bus.img_done), 32'd0);
        end
    endtask

    task automatic push_expected();
        exp_t e;
        for (int n = 0; n < N_OUT; n++) begin
            e.idx  = n;
            e.data = golden(n);
            q.push_back(e);
        end
    endtask

    task automatic run_image(input int stall_idx, input int stall_len);
        push_expected();
        load_image();
        collect(N_OUT, stall_idx, stall_len);
    endtask

    task automatic fill_random();
        for (int k = 0; k < N_IN; k++) pix_mem[k] = int'($urandom_range(0, 255));
        for (int a = 0; a < NW; a++) wmem[a] = int'($urandom_range(0, 6)) - 3;
        for (int n = 0; n < N_OUT; n++) bmem[n] = int'($urandom_range(0, 4000)) - 2000;
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_data  = 8'd0;
        bus.out_ready = 1'b1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_pix_ready", 32'(bus.pix_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_idx", 32'(bus.out_idx), 32'd0);
        check("rst_w_addr", 32'(bus.w_addr), 32'd0);
        check("rst_b_addr", 32'(bus.b_addr), 32'd0);
        check("rst_img_done", 32'(bus.img_done), 32'd0);

        // Addressing and ordering: out_data = 3n, w_addr walks 0..NW-1
        for (int k = 0; k < N_IN; k++) pix_mem[k] = 1;
        for (int a = 0; a < NW; a++) wmem[a] = a / N_IN;
        for (int n = 0; n < N_OUT; n++) bmem[n] = 0;
        prev_addr = 0;
        addr_mon  = 1'b1;
        run_image(-1, 0);
        addr_mon  = 1'b0;
        check("w_addr_final", 32'(prev_addr), 32'(NW - 1));

        // Saturation high
        for (int k = 0; k < N_IN; k++) pix_mem[k] = 255;
        for (int a = 0; a < NW; a++) wmem[a] = 1;
        run_image(-1, 0);

        // ReLU clamp of a negative sum
        for (int k = 0; k < N_IN; k++) pix_mem[k] = 10;
        for (int a = 0; a < NW; a++) wmem[a] = -1;
        run_image(-1, 0);

        // Bias only: even neurons 1280 -> 5, odd neurons -1 -> 0
        for (int k = 0; k < N_IN; k++) pix_mem[k] = 0;
        for (int n = 0; n < N_OUT; n++) bmem[n] = (n % 2 == 0) ? 1280 : -1;
        run_image(-1, 0);

        // Random image with backpressure on neuron 4
        fill_random();
        run_image(4, 20);

        // Reset in the middle of neuron 3, then a fresh image
        fill_random();
        push_expected();
        load_image();
        collect(3, -1, 0);
        repeat (200) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_pix_ready", 32'(bus.pix_ready), 32'd1);
        q.delete();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("post_rst_pix_ready", 32'(bus.pix_ready), 32'd1);
        check("post_rst_w_addr", 32'(bus.w_addr), 32'd0);
        check("post_rst_img_done", 32'(bus.img_done), 32'd0);
        fill_random();
        run_image(-1, 0);
        check("sb_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
